reg_file_scoreboard: RTL and testbench

// - Consumer end of the write-back interface: 32-entry GPR file that commits WB-stage results.
// - Serves ID-stage operand reads with a same-cycle WB bypass.
// - Tracks in-flight destination registers with per-register pending counters.
// - Raises stall when an issuing instruction reads, or over-commits, a register whose result is not back yet.

---
 rtl/reg_file_scoreboard.sv | 122 ++++++++++++
 tb/tb_reg_file_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// 32-entry GPR file committing write-back results, with same-cycle WB bypass on both
// read ports and per-register pending-write counters that drive the issue stall.
module reg_file_scoreboard #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  pend_q [NREG];
  logic [CNT_W-1:0]  pend_d [NREG];
  logic              err_overflow_q, err_overflow_d;
  logic              err_underflow_q, err_underflow_d;

  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   still_pending;
  logic              rs_hazard, rt_hazard, waw_hazard;
  logic              fire;

  // still_pending[r]: writes to r remain outstanding even after this cycle's WB is counted.
  always_comb begin
    wb_hit        = '0;
    still_pending = '0;
    for (int r = 1; r < NREG; r++) begin
      wb_hit[r]        = wb_reg_write && (wb_rd == ADDR_W'(r));
      still_pending[r] = (pend_q[r] > CNT_W'(1)) ||
                         ((pend_q[r] == CNT_W'(1)) && !wb_hit[r]);
    end
  end

  always_comb begin
    rs_hazard  = rs_used && (rs_addr != '0) && still_pending[rs_addr];
    rt_hazard  = rt_used && (rt_addr != '0) && still_pending[rt_addr];
    waw_hazard = issue_we && (issue_rd != '0) &&
                 (pend_q[issue_rd] == CNT_MAX) && !wb_hit[issue_rd];
    stall      = !rst && issue_valid && (rs_hazard || rt_hazard || waw_hazard);
    fire       = issue_valid && !stall && issue_we && (issue_rd != '0);
  end

  // Read ports are forced to zero during reset so the bypass cannot leak wb_data.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (!rst && (rs_addr != '0)) begin
      rs_data = (wb_reg_write && (wb_rd == rs_addr)) ? wb_data : regs_q[rs_addr];
    end
    if (!rst && (rt_addr != '0)) begin
      rt_data = (wb_reg_write && (wb_rd == rt_addr)) ? wb_data : regs_q[rt_addr];
    end
  end

  // A fire and a WB hitting the same register cancel, leaving its counter untouched.
  always_comb begin
    regs_d          = regs_q;
    pend_d          = pend_q;
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;
    if (wb_reg_write && (wb_rd != '0)) begin
      regs_d[wb_rd] = wb_data;
    end
    for (int r = 1; r < NREG; r++) begin
      if (fire && (issue_rd == ADDR_W'(r)) && !wb_hit[r]) begin
        if (pend_q[r] == CNT_MAX) begin
          err_overflow_d = 1'b1;
        end else begin
          pend_d[r] = pend_q[r] + CNT_W'(1);
        end
      end else if (wb_hit[r] && !(fire && (issue_rd == ADDR_W'(r)))) begin
        if (pend_q[r] == '0) begin
          err_underflow_d = 1'b1;
        end else begin
          pend_d[r] = pend_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
        pend_q[r] <= pend_d[r];
      end
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: a driver pushes expected outputs from an
// array-based reference model; an independent monitor pops and compares every cycle.
module tb_reg_file_scoreboard;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int MAXI = 3;
  localparam int NR   = 32;
  localparam int EW   = 3 + 2 * DW;

  // clock / reset / DUT
  logic          clk = 1'b0;
  logic          rst;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          issue_valid, issue_we;
  logic [AW-1:0] issue_rd;
  logic          rs_used, rt_used;
  logic [AW-1:0] rs_addr, rt_addr;
  logic [DW-1:0] rs_data, rt_data;
  logic          stall, err_overflow, err_underflow;

  always #5 clk = ~clk;

  reg_file_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .rs_used(rs_used), .rt_used(rt_used), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // reference model and scoreboard
  logic [DW-1:0] m_regs [NR];
  int            m_pend [NR];
  bit            m_ov, m_un;
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  function automatic int hit(input logic wr, input logic [AW-1:0] wrd, input logic [AW-1:0] a);
    return (wr && wrd == a && a != 0) ? 1 : 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  // driver: one call = one clock cycle of stimulus
  task automatic step(input logic r, input logic wr, input logic [AW-1:0] wrd,
                      input logic [DW-1:0] wd, input logic iv, input logic iwe,
                      input logic [AW-1:0] ird, input logic rsu, input logic rtu,
                      input logic [AW-1:0] rsa, input logic [AW-1:0] rta);
    logic [DW-1:0] rs_e, rt_e;
    bit            st_e, fire;
    @(negedge clk);
    cyc++;
    rst = r; wb_reg_write = wr; wb_rd = wrd; wb_data = wd;
    issue_valid = iv; issue_we = iwe; issue_rd = ird;
    rs_used = rsu; rt_used = rtu; rs_addr = rsa; rt_addr = rta;
    if (r) begin
      model_clear();
      exp_q.push_back('0);
      return;
    end
    st_e = iv && ((rsu && rsa != 0 && (m_pend[rsa] - hit(wr, wrd, rsa)) > 0) ||
                  (rtu && rta != 0 && (m_pend[rta] - hit(wr, wrd, rta)) > 0) ||
                  (iwe && ird != 0 && m_pend[ird] == MAXI && hit(wr, wrd, ird) == 0));
    rs_e = (rsa == 0) ? '0 : (wr && wrd == rsa) ? wd : m_regs[rsa];
    rt_e = (rta == 0) ? '0 : (wr && wrd == rta) ? wd : m_regs[rta];
    exp_q.push_back({st_e, m_ov, m_un, rs_e, rt_e});
    fire = iv && !st_e && iwe && ird != 0;
    if (wr && wrd != 0) m_regs[wrd] = wd;
    if (!(fire && hit(wr, wrd, ird) == 1)) begin
      if (fire) begin
        if (m_pend[ird] == MAXI) m_ov = 1'b1;
        else m_pend[ird]++;
      end
      if (hit(wr, wrd, wrd) == 1) begin
        if (m_pend[wrd] == 0) m_un = 1'b1;
        else m_pend[wrd]--;
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] rsa, input logic [AW-1:0] rta);
    step(0, 0, 0, '0, 0, 0, 0, 1, 1, rsa, rta);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // monitor: outputs are always presented, so one entry is consumed per driven cycle
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",         DW'(stall),         DW'(e[EW-1]));
        chk("err_overflow",  DW'(err_overflow),  DW'(e[EW-2]));
        chk("err_underflow", DW'(err_underflow), DW'(e[EW-3]));
        chk("rs_data",       rs_data,            e[2*DW-1:DW]);
        chk("rt_data",       rt_data,            e[DW-1:0]);
      end
    end
  end

  initial begin
    int            n;
    logic          wr, iv;
    logic [AW-1:0] wrd, ird;
    rst = 1'b1; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    issue_valid = 0; issue_we = 0; issue_rd = 0;
    rs_used = 0; rt_used = 0; rs_addr = 0; rt_addr = 0;
    model_clear();

    // reset state
    step(1, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 32'h1111, 1, 1, 5, 1, 1, 5, 5);

    // mid-run reset after r5=0x1234 committed with pend[5]=2
    repeat (3) step(0, 0, 0, '0, 1, 1, 5, 0, 0, 0, 0);
    step(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle(5, 5);
    step(1, 1, 5, 32'hAAAA, 1, 1, 5, 1, 1, 5, 5);
    idle(5, 0);

    // commit with same-cycle bypass, then from the array
    step(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 1, 1, 7, 0);
    idle(7, 7);

    // RAW stall until the producing WB arrives
    step(0, 0, 0, '0, 1, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 1, 0, 3, 0);
    step(0, 0, 0, '0, 1, 0, 0, 1, 0, 3, 0);
    step(0, 1, 3, 32'h55AA, 1, 0, 0, 1, 0, 3, 0);

    // register 0
    step(0, 1, 0, 32'hFFFF, 1, 1, 0, 1, 1, 0, 0);
    idle(0, 0);

    // WAW cap at MAX_INFLIGHT, and release by a same-cycle WB
    repeat (3) step(0, 0, 0, '0, 1, 1, 9, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 1, 9, 0, 0, 0, 0);
    step(0, 1, 9, 32'h9999, 1, 1, 9, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 1, 9, 0, 0, 0, 0);
    repeat (3) step(0, 1, 9, 32'h0909, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 1, 1, 9, 9);

    // underflow: data still committed, flag sticky
    step(0, 1, 12, 32'h0C0C, 0, 0, 0, 0, 0, 0, 0);
    idle(12, 9);
    idle(0, 12);

    // randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      wrd = AW'($urandom_range(0, 7));
      wr  = (m_pend[wrd] > 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      ird = AW'($urandom_range(0, 7));
      step(($urandom_range(0, 299) == 0), wr, wrd, $urandom, iv, $urandom_range(0, 1),
           ird, $urandom_range(0, 1), $urandom_range(0, 1),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    // bounded drain of the scoreboard
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #3;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
